// File: rtl/adc_dly_pkg.sv
// Shared types and sizing helpers for the ADC IDELAYE3 tap-load sequencer.
package adc_dly_pkg;

  localparam int TAP_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    VTC_OFF = 3'd2,
    LOAD    = 3'd3,
    CHECK   = 3'd4,
    VTC_ON  = 3'd5,
    DONE    = 3'd6
  } dly_state_t;

  // The settle counter only ever holds VTC_SETTLE-1 (or 1 for CHECK).
  function automatic int settle_cnt_w(input int settle);
    return (settle > 2) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/adc_idelay_ctrl.sv
// Walks the masked ADC lanes on a strobe edge: EN_VTC off, LOAD, verify, EN_VTC on.
module adc_idelay_ctrl
  import adc_dly_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int TAP_W      = TAP_W_DEF,
  parameter int VTC_SETTLE = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [TAP_W-1:0]             dly_val,
  input  logic [NUM_LANES-1:0]         dly_lane_mask,
  input  logic                         dly_strobe,
  input  logic [$clog2(NUM_LANES)-1:0] rd_sel,
  output logic [NUM_LANES-1:0]         idly_en_vtc,
  output logic [NUM_LANES-1:0]         idly_load,
  output logic [TAP_W-1:0]             idly_cntvaluein,
  input  logic [NUM_LANES*TAP_W-1:0]   idly_cntvalueout,
  output logic [TAP_W-1:0]             rd_tap,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_LANES-1:0]         dly_err
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int CNT_W  = settle_cnt_w(VTC_SETTLE);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(VTC_SETTLE - 1);
  localparam logic [CNT_W-1:0]  CHECK_LD  = CNT_W'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  dly_state_t r_state, w_state_nx;
  logic [LANE_W-1:0]    r_lane, w_lane_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [TAP_W-1:0]     r_val;
  logic [NUM_LANES-1:0] r_mask;
  logic                 r_strb_d;

  logic [NUM_LANES-1:0] r_en_vtc;
  logic [NUM_LANES-1:0] r_load;
  logic [TAP_W-1:0]     r_cntin;
  logic [TAP_W-1:0]     r_rd_tap;
  logic                 r_busy;
  logic                 r_done;
  logic [NUM_LANES-1:0] r_err;

  logic                 w_start;
  logic                 w_last;
  logic                 w_cnt_zero;
  logic                 w_verify;
  logic [TAP_W-1:0]     w_lane_tap;
  logic [NUM_LANES-1:0] w_cur_oh;
  logic [NUM_LANES-1:0] w_nx_oh;
  logic                 w_nx_vtc_low;

  assign w_start    = dly_strobe & ~r_strb_d & (r_state == IDLE);
  assign w_last     = (r_lane == LAST_LANE);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_verify   = (r_state == CHECK) & w_cnt_zero;
  assign w_lane_tap = idly_cntvalueout[int'(r_lane)*TAP_W +: TAP_W];
  assign w_cur_oh   = NUM_LANES'(1) << r_lane;
  assign w_nx_oh    = NUM_LANES'(1) << w_lane_nx;
  assign w_nx_vtc_low = (w_state_nx == VTC_OFF) | (w_state_nx == LOAD) |
                        (w_state_nx == CHECK);

  always_comb begin
    w_state_nx = r_state;
    w_lane_nx  = r_lane;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nx = SCAN;
          w_lane_nx  = '0;
        end
      end
      SCAN: begin
        if (r_mask[r_lane]) begin
          w_state_nx = VTC_OFF;
          w_cnt_nx   = SETTLE_LD;
        end else if (w_last) begin
          w_state_nx = DONE;
        end else begin
          w_lane_nx = r_lane + 1'b1;
        end
      end
      VTC_OFF: begin
        if (w_cnt_zero) w_state_nx = LOAD;
        else            w_cnt_nx   = r_cnt - 1'b1;
      end
      LOAD: begin
        w_state_nx = CHECK;
        w_cnt_nx   = CHECK_LD;
      end
      CHECK: begin
        if (w_cnt_zero) begin
          w_state_nx = VTC_ON;
          w_cnt_nx   = SETTLE_LD;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      VTC_ON: begin
        if (!w_cnt_zero) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (w_last) begin
          w_state_nx = DONE;
        end else begin
          w_state_nx = SCAN;
          w_lane_nx  = r_lane + 1'b1;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_lane   <= '0;
      r_cnt    <= '0;
      r_val    <= '0;
      r_mask   <= '0;
      r_strb_d <= 1'b1;
      r_en_vtc <= '1;
      r_load   <= '0;
      r_cntin  <= '0;
      r_rd_tap <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_lane   <= w_lane_nx;
      r_cnt    <= w_cnt_nx;
      r_strb_d <= dly_strobe;
      r_rd_tap <= idly_cntvalueout[int'(rd_sel)*TAP_W +: TAP_W];
      // Outputs are decoded from the next state so they line up with it.
      r_en_vtc <= w_nx_vtc_low ? ~w_nx_oh : '1;
      r_load   <= (w_state_nx == LOAD) ? w_nx_oh : '0;
      r_busy   <= (w_state_nx != IDLE);
      r_done   <= (w_state_nx == DONE);
      if (w_start) begin
        r_val   <= dly_val;
        r_mask  <= dly_lane_mask;
        r_cntin <= dly_val;
        r_err   <= '0;
      end else if (w_verify && (w_lane_tap != r_val)) begin
        r_err <= r_err | w_cur_oh;
      end
    end
  end

  assign idly_en_vtc     = r_en_vtc;
  assign idly_load       = r_load;
  assign idly_cntvaluein = r_cntin;
  assign rd_tap          = r_rd_tap;
  assign busy            = r_busy;
  assign done            = r_done;
  assign dly_err         = r_err;

endmodule

// File: tb/tb_adc_idelay_ctrl.sv
// Directed bench for adc_idelay_ctrl with a lane model and an event scoreboard.
module tb_adc_idelay_ctrl;

  localparam int NL = 4;
  localparam int TW = 9;
  localparam int VS = 4;
  localparam int PER_LANE = 2*VS + 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [TW-1:0] dly_val;
  logic [NL-1:0] dly_lane_mask;
  logic          dly_strobe;
  logic [1:0]    rd_sel;
  logic [NL-1:0] idly_en_vtc;
  logic [NL-1:0] idly_load;
  logic [TW-1:0] idly_cntvaluein;
  logic [NL*TW-1:0] idly_cntvalueout;
  logic [TW-1:0] rd_tap;
  logic          busy;
  logic          done;
  logic [NL-1:0] dly_err;

  adc_idelay_ctrl #(.NUM_LANES(NL), .TAP_W(TW), .VTC_SETTLE(VS)) dut (
    .aclk(aclk), .aresetn(aresetn), .dly_val(dly_val),
    .dly_lane_mask(dly_lane_mask), .dly_strobe(dly_strobe), .rd_sel(rd_sel),
    .idly_en_vtc(idly_en_vtc), .idly_load(idly_load),
    .idly_cntvaluein(idly_cntvaluein), .idly_cntvalueout(idly_cntvalueout),
    .rd_tap(rd_tap), .busy(busy), .done(done), .dly_err(dly_err)
  );

  always #5 aclk = ~aclk;

  // Lane model: tap register loads CNTVALUEIN on LOAD; lane 1 can be forced to 0.
  logic [TW-1:0] tap [NL];
  logic          force_err = 1'b0;
  initial for (int i = 0; i < NL; i++) tap[i] = '0;
  always @(posedge aclk)
    for (int i = 0; i < NL; i++) if (idly_load[i]) tap[i] <= idly_cntvaluein;
  always_comb
    for (int i = 0; i < NL; i++)
      idly_cntvalueout[i*TW +: TW] = (force_err && i == 1) ? '0 : tap[i];

  int cyc = 0;
  int e_cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  typedef struct {
    logic          is_done;
    int            lane;
    int            rel;
    logic [TW-1:0] val;
  } ev_t;
  ev_t sb[$];

  logic prev_done = 1'b0;
  always @(negedge aclk) begin : monitor
    int  rel;
    ev_t ev;
    if (aresetn) begin
      rel = cyc - e_cyc + 1;
      if (busy) begin
        check("vtc_excl", 32'($countones(~idly_en_vtc) <= 1), 32'd1);
        check("load_in_win", 32'(idly_load & idly_en_vtc), 32'd0);
      end
      if (prev_done) check("busy_fall", 32'(busy), 32'd0);
      if (idly_load != '0 || done) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {idly_load, 27'd0, done}, 32'd0);
        end else begin
          ev = sb.pop_front();
          check("ev_kind", 32'(done), 32'(ev.is_done));
          check("ev_rel", 32'(rel), 32'(ev.rel));
          if (ev.is_done) begin
            check("done_load", 32'(idly_load), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
            check("done_cntin", 32'(idly_cntvaluein), 32'(ev.val));
          end else begin
            check("load_lane", 32'(idly_load), 32'(1 << ev.lane));
            check("load_vtc", 32'(idly_en_vtc[ev.lane]), 32'd0);
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic start_seq(input logic [TW-1:0] val, input logic [NL-1:0] mask);
    int  m;
    ev_t ev;
    @(negedge aclk);
    dly_val       = val;
    dly_lane_mask = mask;
    dly_strobe    = 1'b1;
    e_cyc         = cyc + 1;
    m = 0;
    for (int l = 0; l < NL; l++) begin
      if (mask[l]) begin
        ev.is_done = 1'b0; ev.lane = l; ev.rel = 1 + l + PER_LANE*m + VS + 1; ev.val = val;
        sb.push_back(ev);
        m++;
      end
    end
    ev.is_done = 1'b1; ev.lane = 0; ev.rel = 1 + NL + PER_LANE*m; ev.val = val;
    sb.push_back(ev);
    @(negedge aclk);
    dly_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge aclk);
    check(tag, 32'(sb.size()), 32'd0);
    @(negedge aclk);
    @(negedge aclk);
  endtask

  task automatic wait_rel(input int r);
    for (int i = 0; i < 200 && (cyc - e_cyc + 1) != r; i++) @(negedge aclk);
    check("wait_rel", 32'(cyc - e_cyc + 1), 32'(r));
  endtask

  initial begin
    aresetn = 1'b0; dly_strobe = 1'b1; dly_val = '0; dly_lane_mask = '0; rd_sel = '0;
    repeat (3) @(negedge aclk);
    check("rst_en_vtc", 32'(idly_en_vtc), 32'hF);
    check("rst_load", 32'(idly_load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(dly_err), 32'd0);
    check("rst_cntin", 32'(idly_cntvaluein), 32'd0);
    check("rst_rdtap", 32'(rd_tap), 32'd0);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    check("no_start_busy", 32'(busy), 32'd0);
    check("no_start_vtc", 32'(idly_en_vtc), 32'hF);
    dly_strobe = 1'b0;
    repeat (2) @(negedge aclk);

    // Full load after successive register writes.
    dly_val = 9'h001; @(negedge aclk);
    dly_val = 9'h002; @(negedge aclk);
    start_seq(9'h003, 4'hF);
    wait_idle("full_timeout");
    check("full_err", 32'(dly_err), 32'd0);
    check("full_cntin", 32'(idly_cntvaluein), 32'h3);
    for (int i = 0; i < NL; i++) begin
      rd_sel = 2'(i);
      @(negedge aclk);
      check("rd_tap", 32'(rd_tap), 32'h3);
    end

    start_seq(9'h1FF, 4'b0100);
    wait_idle("sparse_timeout");
    check("sparse_err", 32'(dly_err), 32'd0);
    rd_sel = 2'd2; @(negedge aclk); @(negedge aclk);
    check("sparse_rd2", 32'(rd_tap), 32'h1FF);
    rd_sel = 2'd1; @(negedge aclk); @(negedge aclk);
    check("sparse_rd1", 32'(rd_tap), 32'h3);

    // Re-edges and register changes while busy must be ignored.
    start_seq(9'h0A7, 4'hF);
    wait_rel(10);
    dly_strobe = 1'b1; dly_val = 9'h011; dly_lane_mask = 4'h1;
    @(negedge aclk); dly_strobe = 1'b0;
    repeat (5) @(negedge aclk); dly_strobe = 1'b1;
    @(negedge aclk); dly_strobe = 1'b0;
    wait_idle("reedge_timeout");
    check("reedge_cntin", 32'(idly_cntvaluein), 32'h0A7);
    repeat (40) @(negedge aclk);
    check("reedge_idle", 32'(busy), 32'd0);

    force_err = 1'b1;
    start_seq(9'h055, 4'hF);
    wait_idle("err_timeout");
    check("err_set", 32'(dly_err), 32'b0010);
    force_err = 1'b0;
    start_seq(9'h055, 4'hF);
    wait_idle("clr_timeout");
    check("err_clear", 32'(dly_err), 32'd0);

    // Reset in the middle of lane 2 VTC_OFF.
    start_seq(9'h0C3, 4'hF);
    wait_rel(1 + 2 + 2*PER_LANE + 2);
    check("mid_vtc", 32'(idly_en_vtc), 32'b1011);
    check("mid_busy", 32'(busy), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("abort_vtc", 32'(idly_en_vtc), 32'hF);
    check("abort_load", 32'(idly_load), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    check("abort_no_resume", 32'(busy), 32'd0);
    start_seq(9'h12C, 4'hF);
    wait_idle("after_rst_timeout");
    check("after_rst_err", 32'(dly_err), 32'd0);
    check("after_rst_cntin", 32'(idly_cntvaluein), 32'h12C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
